exc_sequencer: RTL and testbench
================================

// Module: exc_sequencer
// PURPOSE
//  Parametrised exception sequencer; successor to the monolithic exception states of the control unit.
//  Accepts NCAUSE prioritised exception requests (overflow, bad opcode, div-by-0, ...) and stalls the core.
//  Writes EPC = PC-4 and the cause code, then reads a one-byte handler address from memory at VEC_BASE+cause.
//  Loads that address into PC. Adds request masking, pending capture, back-to-back service and fetch timeout.
// PARAMETERS
//  NCAUSE    3    number of exception sources; bit 0 = highest priority
//  CAUSE_W   2    width of cause code; must satisfy 2**CAUSE_W >= NCAUSE
//  ADDR_W    32   PC/EPC/memory address width
//  VEC_BASE  253  address of the vector byte for cause 0; cause k reads VEC_BASE+k
//  TIMEOUT   8    max FETCH cycles waiting for mem_rd_ack before fault; must be >= 1
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-low reset (0 = reset)
//  exc_req      in   NCAUSE   exception request bits; one-cycle pulses or levels
//  exc_mask     in   NCAUSE   1 = source masked; its request is held pending, not serviced
//  pc_in        in   ADDR_W   PC of the instruction after the faulting one
//  mem_rdata    in   8        memory read byte; valid when mem_rd_ack=1
//  mem_rd_ack   in   1        memory read complete
//  clr_fault    in   1        clears the sticky fault flag
//  cpu_stall    out  1        1 whenever state != IDLE
//  epc_we       out  1        EPC write strobe; single cycle
//  epc_out      out  ADDR_W   pc_in-4 at capture time, modulo 2**ADDR_W
//  cause_out    out  CAUSE_W  index of the serviced cause; valid while epc_we=1 and held afterwards
//  mem_rd_req   out  1        memory read request
//  mem_addr     out  ADDR_W   VEC_BASE + cause, zero-extended
//  pc_we        out  1        PC write strobe; single cycle
//  pc_out       out  ADDR_W   mem_rdata, zero-extended
//  done         out  1        one-cycle pulse, coincident with pc_we
//  fault        out  1        sticky flag: vector fetch timed out
// BEHAVIOUR
//  - Reset (reset=0): all outputs 0 immediately, state=IDLE, pending=0, timeout counter=0.
//    Reset mid-sequence abandons the sequence with no further strobes.
//  - Every cycle: pending <= (pending | exc_req) & ~served_bit.
//  - Eligible set: eff = (pending | exc_req) & ~exc_mask.
//  - IDLE:
//    - If eff != 0: pick lowest set bit k; latch cause=k and epc=pc_in-4; clear bit k from pending -> SAVE.
//    - If eff == 0: remain in IDLE.
//  - SAVE: epc_we=1 for exactly one cycle; epc_out and cause_out driven -> FETCH.
//  - FETCH:
//    - mem_rd_req=1; mem_addr=VEC_BASE+cause; counter increments each cycle.
//    - If mem_rd_ack=1: capture mem_rdata -> LOAD. An ack in the first FETCH cycle is legal.
//    - If counter reaches TIMEOUT without ack: fault<=1, no PC write -> IDLE.
//  - LOAD: pc_we=1 and done=1 for one cycle; pc_out={0,rdata} -> IDLE.
//  - Latency, request to pc_we: 3 + (cycles until ack). Minimum 3: IDLE->SAVE->FETCH(ack)->LOAD.
//  - Requests arriving outside IDLE are captured in pending and serviced next.
//    Back-to-back service: IDLE lasts one cycle between sequences.
//  - Masked bits stay pending until unmasked. Re-requesting an already-pending bit is idempotent.
//  - fault: set wins over a simultaneous clr_fault. Fault does not block new sequences.
//  - epc_out, cause_out, pc_out and mem_addr hold their last values while in IDLE.
// TESTING
//  1. NCAUSE=3, exc_req=001, pc_in=0x40, ack 2 cycles after mem_rd_req, rdata=0x20
//     -> epc_we with epc_out=0x3C, cause_out=0; mem_addr=253; pc_we with pc_out=0x20; done pulses.
//  2. exc_req=110 in one cycle
//     -> cause 1 serviced first (mem_addr 254); then cause 2 (mem_addr 255) after one IDLE cycle.
//  3. TIMEOUT=8, mem_rd_ack held 0
//     -> fault=1 after 8 FETCH cycles; pc_we never asserts; clr_fault=1 then clears fault.
//  4. reset=0 asserted during FETCH
//     -> all outputs 0 before the next clk edge; after release, no strobe without a new request.
//  5. exc_mask=001, exc_req=001 pulse
//     -> no activity; clear mask 10 cycles later -> sequence starts next cycle with cause 0.
//  6. pc_in=0x0
//     -> epc_out=0xFFFFFFFC (wrap-around); request arriving during LOAD serviced immediately after.

Source files
------------

// File: rtl/exc_sequencer.sv
// Exception sequencer: picks the highest-priority unmasked request, writes EPC/cause,
// fetches a one-byte handler vector from VEC_BASE+cause and loads it into the PC.
module exc_sequencer #(
   parameter int NCAUSE   = 3,
   parameter int CAUSE_W  = 2,
   parameter int ADDR_W   = 32,
   parameter int VEC_BASE = 253,
   parameter int TIMEOUT  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCAUSE-1:0] exc_req,
   input  logic [NCAUSE-1:0] exc_mask,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_rd_ack,
   input  logic              clr_fault,
   output logic              cpu_stall,
   output logic              epc_we,
   output logic [ADDR_W-1:0] epc_out,
   output logic [CAUSE_W-1:0] cause_out,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              pc_we,
   output logic [ADDR_W-1:0] pc_out,
   output logic              done,
   output logic              fault
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SAVE  = 2'd1,
      ST_FETCH = 2'd2,
      ST_LOAD  = 2'd3
   } state_t;

   state_t              state_reg;
   logic [NCAUSE-1:0]   pending_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic                epc_we_reg;
   logic [ADDR_W-1:0]   epc_reg;
   logic [CAUSE_W-1:0]  cause_reg;
   logic                mem_rd_req_reg;
   logic [ADDR_W-1:0]   mem_addr_reg;
   logic                pc_we_reg;
   logic [ADDR_W-1:0]   pc_reg;
   logic                done_reg;
   logic                fault_reg;

   logic [NCAUSE-1:0]   req_all;
   logic [NCAUSE-1:0]   eff;
   logic [NCAUSE-1:0]   served_bits;
   logic [NCAUSE-1:0]   pending_next;
   logic [CAUSE_W-1:0]  pick_idx;
   logic                pick_valid;

   // Lowest set bit wins: scan from the top so lower indices overwrite.
   always_comb begin
      req_all    = pending_reg | exc_req;
      eff        = req_all & ~exc_mask;
      pick_valid = |eff;
      pick_idx   = '0;
      for (int i = NCAUSE - 1; i >= 0; i--) begin
         if (eff[i]) begin
            pick_idx = CAUSE_W'(i);
         end
      end
   end

   // Only the cause actually accepted out of IDLE leaves the pending set.
   generate
      for (genvar gi = 0; gi < NCAUSE; gi++) begin : g_served
         assign served_bits[gi] = (state_reg == ST_IDLE) && pick_valid
                                  && (pick_idx == CAUSE_W'(gi));
      end
   endgenerate

   assign pending_next = req_all & ~served_bits;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         pending_reg    <= '0;
         cnt_reg        <= '0;
         epc_we_reg     <= 1'b0;
         epc_reg        <= '0;
         cause_reg      <= '0;
         mem_rd_req_reg <= 1'b0;
         mem_addr_reg   <= '0;
         pc_we_reg      <= 1'b0;
         pc_reg         <= '0;
         done_reg       <= 1'b0;
         fault_reg      <= 1'b0;
      end else begin
         pending_reg <= pending_next;
         epc_we_reg  <= 1'b0;
         pc_we_reg   <= 1'b0;
         done_reg    <= 1'b0;
         if (clr_fault) begin
            fault_reg <= 1'b0;
         end
         case (state_reg)
            ST_IDLE: begin
               if (pick_valid) begin
                  cause_reg  <= pick_idx;
                  epc_reg    <= pc_in - ADDR_W'(4);
                  epc_we_reg <= 1'b1;
                  state_reg  <= ST_SAVE;
               end
            end
            ST_SAVE: begin
               mem_rd_req_reg <= 1'b1;
               mem_addr_reg   <= ADDR_W'(VEC_BASE) + ADDR_W'(cause_reg);
               cnt_reg        <= '0;
               state_reg      <= ST_FETCH;
            end
            ST_FETCH: begin
               if (mem_rd_ack) begin
                  pc_reg         <= ADDR_W'(mem_rdata);
                  pc_we_reg      <= 1'b1;
                  done_reg       <= 1'b1;
                  mem_rd_req_reg <= 1'b0;
                  cnt_reg        <= '0;
                  state_reg      <= ST_LOAD;
               end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                  // Placed after the clear so a timeout in the same cycle keeps fault set.
                  fault_reg      <= 1'b1;
                  mem_rd_req_reg <= 1'b0;
                  cnt_reg        <= '0;
                  state_reg      <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_LOAD: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_stall  = (state_reg != ST_IDLE);
   assign epc_we     = epc_we_reg;
   assign epc_out    = epc_reg;
   assign cause_out  = cause_reg;
   assign mem_rd_req = mem_rd_req_reg;
   assign mem_addr   = mem_addr_reg;
   assign pc_we      = pc_we_reg;
   assign pc_out     = pc_reg;
   assign done       = done_reg;
   assign fault      = fault_reg;

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: expectations queued at stimulus time,
// checked by a monitor when EPC writes, vector fetches and PC writes appear.
module tb_exc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  exc_req;
   logic [2:0]  exc_mask;
   logic [31:0] pc_in;
   logic [7:0]  mem_rdata;
   logic        mem_rd_ack;
   logic        clr_fault;
   logic        cpu_stall, epc_we, mem_rd_req, pc_we, done, fault;
   logic [31:0] epc_out, mem_addr, pc_out;
   logic [1:0]  cause_out;

   exc_sequencer #(
      .NCAUSE(3), .CAUSE_W(2), .ADDR_W(32), .VEC_BASE(253), .TIMEOUT(8)
   ) dut (
      .clk(clk), .reset(reset), .exc_req(exc_req), .exc_mask(exc_mask),
      .pc_in(pc_in), .mem_rdata(mem_rdata), .mem_rd_ack(mem_rd_ack),
      .clr_fault(clr_fault), .cpu_stall(cpu_stall), .epc_we(epc_we),
      .epc_out(epc_out), .cause_out(cause_out), .mem_rd_req(mem_rd_req),
      .mem_addr(mem_addr), .pc_we(pc_we), .pc_out(pc_out), .done(done),
      .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] epc;
      logic [1:0]  cause;
   } seq_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int epc_cnt = 0;
   int done_cnt = 0;
   int fetch_len = 0;
   int last_fetch_len = 0;
   int epc_cycs[$];
   int done_cycs[$];
   seq_t        exp_seq_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_pc_q[$];
   logic [7:0]  mem [256];
   logic        req_prev = 1'b0;
   seq_t        mon_s;
   bit          ack_en = 1'b1;
   int          ack_delay = 0;
   int          fcnt = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_seq(input logic [31:0] epc, input logic [1:0] cause, input bit with_pc);
      logic [31:0] addr;
      seq_t s;
      addr = 32'd253 + 32'(cause);
      s.epc = epc;
      s.cause = cause;
      exp_seq_q.push_back(s);
      exp_addr_q.push_back(addr);
      if (with_pc) exp_pc_q.push_back(32'(mem[addr[7:0]]));
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_req(input logic [2:0] r);
      exc_req = r;
      tick();
      exc_req = 3'b000;
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         tick();
         n++;
      end
      check_val(tag, 64'(done_cnt), 64'(target));
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: acks after ack_delay FETCH cycles without ack.
   always @(negedge clk) begin
      if (!reset || !mem_rd_req) begin
         fcnt = 0;
         mem_rd_ack = 1'b0;
         mem_rdata = 8'h00;
      end else begin
         fcnt++;
         if (ack_en && fcnt > ack_delay) begin
            mem_rd_ack = 1'b1;
            mem_rdata = mem[mem_addr[7:0]];
         end else begin
            mem_rd_ack = 1'b0;
            mem_rdata = 8'($urandom);
         end
      end
   end

   always @(negedge clk) begin
      if (epc_we) begin
         epc_cnt++;
         epc_cycs.push_back(cyc);
         $display("txn epc_we cyc=%0d cause=%0d epc=0x%08h", cyc, cause_out, epc_out);
         if (exp_seq_q.size() == 0) begin
            check_val("unexpected_epc_we", 64'd1, 64'd0);
         end else begin
            mon_s = exp_seq_q.pop_front();
            check_val("epc_out", 64'(epc_out), 64'(mon_s.epc));
            check_val("cause_out", 64'(cause_out), 64'(mon_s.cause));
         end
      end
      if (mem_rd_req && !req_prev) begin
         fetch_len = 0;
         $display("txn fetch cyc=%0d addr=%0d", cyc, mem_addr);
         if (exp_addr_q.size() == 0) check_val("unexpected_fetch", 64'd1, 64'd0);
         else check_val("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
      end
      if (mem_rd_req) fetch_len++;
      if (!mem_rd_req && req_prev) last_fetch_len = fetch_len;
      req_prev = mem_rd_req;
      if (pc_we) begin
         done_cnt++;
         done_cycs.push_back(cyc);
         $display("txn pc_we cyc=%0d pc=0x%08h", cyc, pc_out);
         check_val("done_with_pc_we", 64'(done), 64'd1);
         if (exp_pc_q.size() == 0) check_val("unexpected_pc_we", 64'd1, 64'd0);
         else check_val("pc_out", 64'(pc_out), 64'(exp_pc_q.pop_front()));
      end
   end

   initial begin
      int req_cyc, mark, e0, d0, n;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
      mem[253] = 8'h20;
      reset = 1'b0;
      exc_req = 3'b000;
      exc_mask = 3'b000;
      pc_in = 32'h0;
      clr_fault = 1'b0;
      tick();
      check_val("rst_outs", 64'(|{cpu_stall, epc_we, epc_out, cause_out, mem_rd_req,
                                  mem_addr, pc_we, pc_out, done, fault}), 64'd0);
      tick();
      reset = 1'b1;
      tick();

      // 1: single request, ack on third FETCH cycle
      ack_en = 1'b1; ack_delay = 2; pc_in = 32'h40;
      expect_seq(32'h3C, 2'd0, 1'b1);
      req_cyc = cyc;
      d0 = done_cnt;
      pulse_req(3'b001);
      wait_done(d0 + 1, 40, "t1_done");
      check_val("t1_latency", 64'(done_cycs[$] - req_cyc), 64'd5);
      tick();
      check_val("t1_stall_idle", 64'(cpu_stall), 64'd0);
      check_val("t1_no_fault", 64'(fault), 64'd0);

      // 2: two simultaneous requests, priority and one-cycle IDLE gap
      ack_delay = 0; pc_in = 32'h100;
      expect_seq(32'hFC, 2'd1, 1'b1);
      expect_seq(32'hFC, 2'd2, 1'b1);
      req_cyc = cyc;
      d0 = done_cnt;
      pulse_req(3'b110);
      wait_done(d0 + 2, 60, "t2_done");
      check_val("t2_min_latency", 64'(done_cycs[done_cycs.size() - 2] - req_cyc), 64'd3);
      check_val("t2_b2b_gap", 64'(epc_cycs[$] - done_cycs[done_cycs.size() - 2]), 64'd2);
      tick();

      // 3: fetch timeout, sticky fault, then clear
      ack_en = 1'b0; pc_in = 32'h200;
      expect_seq(32'h1FC, 2'd1, 1'b0);
      d0 = done_cnt;
      pulse_req(3'b010);
      n = 0;
      while (!fault && n < 40) begin tick(); n++; end
      check_val("t3_fault_set", 64'(fault), 64'd1);
      check_val("t3_fetch_cycles", 64'(last_fetch_len), 64'd8);
      check_val("t3_no_pc_we", 64'(done_cnt), 64'(d0));
      repeat (3) tick();
      check_val("t3_fault_sticky", 64'(fault), 64'd1);
      clr_fault = 1'b1;
      tick();
      clr_fault = 1'b0;
      check_val("t3_fault_clr", 64'(fault), 64'd0);

      // 3b: timeout while clr_fault is held: set wins for that cycle
      clr_fault = 1'b1;
      expect_seq(32'h1FC, 2'd1, 1'b0);
      pulse_req(3'b010);
      n = 0;
      while (!fault && n < 40) begin tick(); n++; end
      check_val("t3b_set_wins", 64'(fault), 64'd1);
      check_val("t3b_idle_after_to", 64'(cpu_stall), 64'd0);
      tick();
      check_val("t3b_clr_next", 64'(fault), 64'd0);
      clr_fault = 1'b0;

      // 4: asynchronous reset during FETCH
      pc_in = 32'h300;
      expect_seq(32'h2FC, 2'd0, 1'b0);
      pulse_req(3'b001);
      n = 0;
      while (!mem_rd_req && n < 20) begin tick(); n++; end
      check_val("t4_in_fetch", 64'(mem_rd_req), 64'd1);
      tick();
      #2 reset = 1'b0;
      #1 check_val("t4_async_outs", 64'(|{cpu_stall, epc_we, epc_out, cause_out, mem_rd_req,
                                           mem_addr, pc_we, pc_out, done, fault}), 64'd0);
      tick();
      reset = 1'b1;
      ack_en = 1'b1;
      e0 = epc_cnt;
      d0 = done_cnt;
      repeat (10) tick();
      check_val("t4_no_epc_after", 64'(epc_cnt), 64'(e0));
      check_val("t4_no_pc_after", 64'(done_cnt), 64'(d0));
      check_val("t4_idle_after", 64'(cpu_stall), 64'd0);

      // 5: masked request held pending until unmasked
      ack_delay = 1; exc_mask = 3'b001; pc_in = 32'h400;
      e0 = epc_cnt;
      pulse_req(3'b001);
      repeat (10) tick();
      check_val("t5_masked_no_epc", 64'(epc_cnt), 64'(e0));
      check_val("t5_masked_idle", 64'(cpu_stall), 64'd0);
      expect_seq(32'h3FC, 2'd0, 1'b1);
      mark = cyc;
      d0 = done_cnt;
      exc_mask = 3'b000;
      wait_done(d0 + 1, 40, "t5_done");
      check_val("t5_start_next_cycle", 64'(epc_cycs[$] - mark), 64'd1);
      tick();

      // 6: EPC wrap-around and a request arriving during LOAD
      ack_delay = 0; pc_in = 32'h0;
      expect_seq(32'hFFFF_FFFC, 2'd0, 1'b1);
      d0 = done_cnt;
      pulse_req(3'b001);
      n = 0;
      while (!pc_we && n < 40) begin tick(); n++; end
      check_val("t6_load_seen", 64'(pc_we), 64'd1);
      mark = cyc;
      expect_seq(32'hFFFF_FFFC, 2'd2, 1'b1);
      pulse_req(3'b100);
      wait_done(d0 + 2, 40, "t6_done");
      check_val("t6_req_in_load_gap", 64'(epc_cycs[$] - mark), 64'd2);
      repeat (3) tick();

      check_val("sb_epc_empty", 64'(exp_seq_q.size()), 64'd0);
      check_val("sb_addr_empty", 64'(exp_addr_q.size()), 64'd0);
      check_val("sb_pc_empty", 64'(exp_pc_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
